io_out_buffer: RTL and testbench

- Output-port buffer directly downstream of the processor's I/O unit.
- Each OUT instruction (control 6'b111101) places one 32-bit word on the I/O unit's out_data. This block captures that word into a small FIFO.
- Words drain to an external peripheral over a valid/ready handshake, in order.
- full is returned to the core as a stall so OUT words are never lost in normal operation.

---
 rtl/io_pkg.sv | 17 +
 rtl/io_out_buffer_if.sv | 30 +++
 rtl/io_fifo_regs.sv | 27 ++
 rtl/io_out_buffer.sv | 100 ++++++++++
 tb/tb_io_out_buffer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared I/O definitions for the I/O unit, output buffer and decoder.
// Holds the data-path width and the IN/OUT control codes.
// No logic beyond a small decode helper.
package io_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] IO_OP_IN  = 6'b111110;
    localparam logic [5:0] IO_OP_OUT = 6'b111101;

    // Only an OUT instruction may strobe the output buffer; IN and all
    // other codes leave it idle.
    function automatic logic io_out_wr_en(input logic [5:0] op, input logic exec);
        return exec && (op == IO_OP_OUT);
    endfunction

endpackage

// File: rtl/io_out_buffer_if.sv
// Bundle between the core-side I/O unit / peripheral and the output buffer.
// Pure wiring: no storage, no latency.
// Carries the write strobe with its full stall, and the dev valid/ready pair.
interface io_out_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_ovf;
    logic              dev_valid;
    logic [DATA_W-1:0] dev_data;
    logic              dev_ready;

    // Environment side: drives writes, clears and the peripheral ready.
    modport master (
        output wr_en, wr_data, clr_ovf, dev_ready,
        input  full, empty, count, overflow, dev_valid, dev_data
    );

    // Buffer side.
    modport slave (
        input  wr_en, wr_data, clr_ovf, dev_ready,
        output full, empty, count, overflow, dev_valid, dev_data
    );
endinterface

// File: rtl/io_fifo_regs.sv
// Register-array storage for the output FIFO: one write port, one async read port.
// Write lands at the clock edge; read data follows raddr combinationally.
// No flow control here; the owner decides when we may assert.
module io_fifo_regs #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; valid tracking lives with the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/io_out_buffer.sv
// Output-port FIFO between the I/O unit's OUT path and an external peripheral.
// Write at edge N is visible on dev_data/dev_valid after edge N; poppable at N+1.
// full stalls the core; a write while full with no pop is dropped and flagged.
module io_out_buffer #(
    parameter int DATA_W = io_pkg::DATA_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input logic               clk,
    input logic               rst,
    io_out_buffer_if.slave    bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] head_data;

    // Flags decode from the registered occupancy only.
    always_comb begin
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);
    end

    // Handshake qualification: a pop frees a slot in the same cycle, so a
    // write while full is still accepted when the head leaves.
    always_comb begin
        pop  = !empty && bus.dev_ready;
        push = bus.wr_en && (!full || pop);
        drop = bus.wr_en && full && !pop;
    end

    io_fifo_regs #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regs (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    // Pointers wrap at DEPTH; count is what tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (push && !pop) begin
            count_q <= count_q + 1'b1;
        end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Sticky drop flag; a fresh drop beats a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    // Outputs: head word falls through; nothing here depends on wr_* directly.
    always_comb begin
        bus.full      = full;
        bus.empty     = empty;
        bus.count     = count_q;
        bus.overflow  = overflow_q;
        bus.dev_valid = !empty;
        bus.dev_data  = head_data;
    end

endmodule

// File: tb/tb_io_out_buffer.sv
module tb_io_out_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    io_out_buffer_if #(.DATA_W(32), .ADDR_W(2)) bus ();

    io_out_buffer #(.DATA_W(32), .DEPTH(4), .ADDR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.clr_ovf   = 1'b0;
        bus.dev_ready = 1'b0;

        // Reset and idle.
        step();
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_valid", 32'(bus.dev_valid), 32'd0);
        rst = 1'b0;
        step();
        step();
        chk("idle_empty", 32'(bus.empty), 32'd1);
        chk("idle_full", 32'(bus.full), 32'd0);
        chk("idle_count", 32'(bus.count), 32'd0);
        chk("idle_valid", 32'(bus.dev_valid), 32'd0);
        chk("idle_ovf", 32'(bus.overflow), 32'd0);

        // Single word, held under backpressure, then popped.
        write_one(32'hAABBCCDD);
        chk("single_valid", 32'(bus.dev_valid), 32'd1);
        chk("single_data", bus.dev_data, 32'hAABBCCDD);
        chk("single_count", 32'(bus.count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data", bus.dev_data, 32'hAABBCCDD);
            chk("hold_valid", 32'(bus.dev_valid), 32'd1);
        end
        bus.dev_ready = 1'b1;
        step();
        bus.dev_ready = 1'b0;
        chk("pop1_empty", 32'(bus.empty), 32'd1);
        chk("pop1_count", 32'(bus.count), 32'd0);

        // Fill, overflow, ordered drain, clear.
        for (int i = 1; i <= 4; i++) write_one(32'(i));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd4);
        write_one(32'd5);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd4);
        chk("ovf_head", bus.dev_data, 32'd1);
        bus.dev_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", bus.dev_data, 32'(i));
            step();
        end
        bus.dev_ready = 1'b0;
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clr_ovf = 1'b1;
        step();
        bus.clr_ovf = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Full with simultaneous pop: write accepted, count stays at 4.
        for (int i = 1; i <= 4; i++) write_one(32'h20 + 32'(i));
        bus.dev_ready = 1'b1;
        write_one(32'd9);
        bus.dev_ready = 1'b0;
        chk("fullpop_count", 32'(bus.count), 32'd4);
        chk("fullpop_ovf", 32'(bus.overflow), 32'd0);
        chk("fullpop_head", bus.dev_data, 32'h22);
        // Drop and clear in the same cycle: set wins.
        bus.clr_ovf = 1'b1;
        write_one(32'hEE);
        chk("ovf_prio", 32'(bus.overflow), 32'd1);
        step();
        bus.clr_ovf = 1'b0;
        chk("ovf_clr2", 32'(bus.overflow), 32'd0);
        bus.dev_ready = 1'b1;
        chk("fp_d0", bus.dev_data, 32'h22);
        step();
        chk("fp_d1", bus.dev_data, 32'h23);
        step();
        chk("fp_d2", bus.dev_data, 32'h24);
        step();
        chk("fp_d3", bus.dev_data, 32'd9);
        step();
        chk("fp_empty", 32'(bus.empty), 32'd1);

        // Streaming with ready held high: occupancy settles at 1.
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                chk("stream_data", bus.dev_data, 32'h10 + 32'(i - 1));
                chk("stream_count", 32'(bus.count), 32'd1);
            end
            bus.wr_en   = 1'b1;
            bus.wr_data = 32'h10 + 32'(i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("stream_last", bus.dev_data, 32'h19);
        step();
        chk("stream_empty", 32'(bus.empty), 32'd1);
        bus.dev_ready = 1'b0;

        // Reset in the middle of a drain.
        for (int i = 1; i <= 4; i++) write_one(32'h30 + 32'(i));
        bus.dev_ready = 1'b1;
        step();
        chk("mid_count", 32'(bus.count), 32'd3);
        chk("mid_head", bus.dev_data, 32'h32);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.dev_valid), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_count", 32'(bus.count), 32'd0);
        step();
        rst = 1'b0;
        bus.dev_ready = 1'b0;
        step();
        chk("post_empty", 32'(bus.empty), 32'd1);
        write_one(32'h5A5A5A5A);
        chk("post_data", bus.dev_data, 32'h5A5A5A5A);
        chk("post_count", 32'(bus.count), 32'd1);
        bus.dev_ready = 1'b1;
        step();
        bus.dev_ready = 1'b0;
        chk("no_stale_empty", 32'(bus.empty), 32'd1);
        chk("no_stale_valid", 32'(bus.dev_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
